conv_encoder: RTL and testbench
===============================

# conv_encoder

Transmit-side K=7, rate-1/2 convolutional encoder with 802.11 puncturing (1/2, 2/3, 3/4) and a one-bit-per-cycle serial output. It produces the coded bit stream that the receive-side Viterbi decoder consumes, using the same generator polynomials, puncture patterns and A-before-B bit order. It sits between the scrambler and the interleaver in the TX chain. Backpressure toward the scrambler is provided by `input_ready`.

## Interface
- No parameters. Generators and rate codes come from the shared package.
- `clock` in 1: sole clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low; clears all state.
- `enable` in 1: clock enable. Low freezes all state; `output_strobe`=0 and `input_ready`=0.
- `rate` in 2: 0=1/2, 1=2/3, 2=3/4, 3=reserved (treated as 1/2). Latched only on `frame_start`.
- `frame_start` in 1: one-cycle pulse. Zeroes the shift register and puncture phase, and latches `rate`.
- `in_bit` in 1: uncoded data bit.
- `input_strobe` in 1: `in_bit` valid. Accepted only when `input_ready`=1.
- `input_ready` out 1: block can accept a bit this cycle.
- `out_bit` out 1: coded bit, registered.
- `output_strobe` out 1: `out_bit` valid, registered, one-cycle per bit.

## Operation
- Encoder state `s[5:0]`; `s[k-1]` = input delayed k.
- A = in ^ s[1] ^ s[2] ^ s[4] ^ s[5] (g0=133 octal).
- B = in ^ s[0] ^ s[1] ^ s[2] ^ s[5] (g1=171 octal).
- On accept, shift `in_bit` into `s`.
- Puncture phase counter `ph`:
  - Rate 1/2: `ph` stays 0; keep A,B.
  - Rate 2/3: period 2. ph0 keeps A,B; ph1 keeps A only.
  - Rate 3/4: period 3. ph0 keeps A,B; ph1 keeps A only; ph2 keeps B only.
- `ph` advances on each accept and wraps at the period end.
- Kept bits are appended to a 2-entry pending buffer, order A then B. Occupancy `cnt` is 0..2.
- Every enabled cycle with `cnt`>0, the head bit moves to `out_bit`, `output_strobe`<=1, and `cnt` decrements.
- `input_ready` = `enable` & (`cnt`<=1). This is combinational from registered `cnt`. When `cnt`=1, the old bit drains in the same cycle the new bits are appended, so the buffer never overflows.
- Simultaneous `frame_start` + accepted input: clear first, then encode the bit from a zero state at `ph`=0 with the newly latched rate.
- `frame_start` does not discard pending bits; they drain unchanged.
- Reset values:
  - `s`=0, `ph`=0, `cnt`=0, latched rate=1/2.
  - `out_bit`=0, `output_strobe`=0, `input_ready`=0 while `reset`=0.
- Reset mid-frame: pending bits are dropped, and there is no output the cycle after reset releases.
- Tail bits are not generated internally; upstream supplies six zero bits.

## Timing
- Latency: bit accepted at cycle N → first coded bit has `output_strobe`=1 at N+1, second at N+2.
- Sustained throughput:
  - Rate 1/2: one input per 2 cycles.
  - Rate 2/3: 2 inputs per 3 cycles.
  - Rate 3/4: 3 inputs per 4 cycles.
  - Output is continuous (`output_strobe` stuck at 1) under a saturating source.
- `enable` low for any number of cycles delays the stream without losing or duplicating bits.

## Structure
- Package `conv_pkg`:
  - `G0`=7'o133, `G1`=7'o171.
  - Rate codes `RATE_1_2`/`RATE_2_3`/`RATE_3_4`.
  - Puncture keep-mask function of (rate, ph) returning {keepA, keepB}.
- Top `conv_encoder`: shift register, phase counter, rate latch.
- One sub-module, `conv_puncture_ser`: pending buffer, `cnt`, serializer, output registers. Takes {A, B, keepA, keepB, push}; returns `out_bit`/`output_strobe` and `cnt`<=1.

## Test plan
- Rate 1/2 impulse: `frame_start`, input 1,0,0,0,0,0,0 saturating → out 11 01 11 11 00 10 11, strobe continuous, `input_ready` toggling 1,0.
- Rate 3/4: `frame_start`, input 1,0,0 → out 1,1,0,1; then the next input 1 restarts at ph0 → 1,1.
- Rate 2/3: input 1,0 → out 1,1,0. Check `input_ready` pattern 1,1,0 repeating under saturation.
- `enable` dropped for 5 cycles mid-stream at rate 3/4 → output sequence identical to the uninterrupted run; no strobes while low.
- `frame_start` with `cnt`=2 pending plus simultaneous input 1 at new rate 1/2 → both old bits emerge first, then 1,1.
- `reset` low mid-frame with `cnt`=2 → next cycle `output_strobe`=0, `input_ready`=0. After release, input 1 yields 1,1 (state zeroed, rate 1/2).

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and helpers for the K=7 rate-1/2 convolutional
// encoder (TX) and its matching Viterbi decoder (RX).
//   G0, G1      : generator polynomials (octal 133 / 171)
//   rate_t      : rate codes as carried on the 2-bit rate port
//   keep_mask   : 802.11 puncture pattern, returns {keep_a, keep_b}
//   phase_last  : final puncture phase before wrap for a given rate
package conv_pkg;

    localparam logic [6:0] G0 = 7'o133;
    localparam logic [6:0] G1 = 7'o171;

    typedef enum logic [1:0] {
        RATE_1_2  = 2'd0,
        RATE_2_3  = 2'd1,
        RATE_3_4  = 2'd2,
        RATE_RSVD = 2'd3
    } rate_t;

    function automatic logic [1:0] keep_mask(input rate_t r, input logic [1:0] ph);
        logic [1:0] keep;
        keep = 2'b11;
        case (r)
            RATE_2_3: keep = (ph == 2'd0) ? 2'b11 : 2'b10;
            RATE_3_4: begin
                case (ph)
                    2'd1:    keep = 2'b10;
                    2'd2:    keep = 2'b01;
                    default: keep = 2'b11;
                endcase
            end
            default:  keep = 2'b11;
        endcase
        return keep;
    endfunction

    function automatic logic [1:0] phase_last(input rate_t r);
        logic [1:0] last;
        case (r)
            RATE_2_3: last = 2'd1;
            RATE_3_4: last = 2'd2;
            default:  last = 2'd0;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/conv_puncture_ser.sv
// conv_puncture_ser: 2-entry pending buffer and one-bit-per-cycle serializer
// for the punctured coded stream.
//   clock, reset (sync, active-low), enable : clocking and freeze control
//   a_bit, b_bit, keep_a, keep_b, push       : coded pair and puncture mask
//   out_bit, output_strobe                   : serial coded output
//   can_accept                               : buffer occupancy <= 1
module conv_puncture_ser (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic a_bit,
    input  logic b_bit,
    input  logic keep_a,
    input  logic keep_b,
    input  logic push,
    output logic out_bit,
    output logic output_strobe,
    output logic can_accept
);

    logic [1:0] pend_q, pend_d;   // pend_q[0] is the head
    logic [1:0] cnt_q, cnt_d;
    logic       out_q, out_d;
    logic       strobe_q, strobe_d;

    always_comb begin
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        strobe_d = 1'b0;
        if (cnt_q != 2'd0) begin
            out_d    = pend_q[0];
            strobe_d = 1'b1;
            pend_d   = {1'b0, pend_q[1]};
            cnt_d    = cnt_q - 2'd1;
        end
        // push only happens with cnt_q <= 1, so the drain above has always
        // emptied the buffer and the new bits land at the head.
        if (push) begin
            case ({keep_a, keep_b})
                2'b11: begin pend_d = {b_bit, a_bit}; cnt_d = 2'd2; end
                2'b10: begin pend_d = {1'b0, a_bit};  cnt_d = 2'd1; end
                2'b01: begin pend_d = {1'b0, b_bit};  cnt_d = 2'd1; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pend_q   <= '0;
            cnt_q    <= '0;
            out_q    <= 1'b0;
            strobe_q <= 1'b0;
        end else if (enable) begin
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            strobe_q <= strobe_d;
        end
    end

    // The strobe register is frozen while disabled; gating it here hides it
    // so a held bit is presented exactly once, after enable returns.
    assign output_strobe = strobe_q & enable & reset;
    assign out_bit       = out_q & reset;
    assign can_accept    = (cnt_q <= 2'd1);

endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: K=7 rate-1/2 convolutional encoder with 802.11 puncturing
// (1/2, 2/3, 3/4) and serial coded output, A before B.
//   clock, reset (sync, active-low), enable : clocking and freeze control
//   rate, frame_start                       : rate latched on frame_start
//   in_bit, input_strobe, input_ready       : uncoded input handshake
//   out_bit, output_strobe                  : serial coded output
module conv_encoder
    import conv_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] rate,
    input  logic       frame_start,
    input  logic       in_bit,
    input  logic       input_strobe,
    output logic       input_ready,
    output logic       out_bit,
    output logic       output_strobe
);

    logic [5:0] s_q, s_eff;
    logic [1:0] ph_q, ph_eff;
    rate_t      rate_q, rate_in, rate_eff;
    logic       fs_act, push, can_accept;
    logic [6:0] win;
    logic       a_bit, b_bit;
    logic [1:0] keep;

    assign fs_act      = enable & frame_start;
    assign input_ready = enable & reset & can_accept;
    assign push        = input_ready & input_strobe;

    // A frame_start coinciding with an accepted bit must encode that bit from
    // the cleared state, so the encoder works on "effective" values.
    always_comb begin
        rate_in = rate_t'(rate);
        if (rate_in == RATE_RSVD) rate_in = RATE_1_2;
        rate_eff = fs_act ? rate_in : rate_q;
        s_eff    = fs_act ? '0 : s_q;
        ph_eff   = fs_act ? '0 : ph_q;
        win      = {in_bit, s_eff[0], s_eff[1], s_eff[2], s_eff[3], s_eff[4], s_eff[5]};
        a_bit    = ^(win & G0);
        b_bit    = ^(win & G1);
        keep     = keep_mask(rate_eff, ph_eff);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            s_q    <= '0;
            ph_q   <= '0;
            rate_q <= RATE_1_2;
        end else if (enable) begin
            rate_q <= rate_eff;
            if (push) begin
                s_q  <= {s_eff[4:0], in_bit};
                ph_q <= (ph_eff == phase_last(rate_eff)) ? 2'd0 : ph_eff + 2'd1;
            end else begin
                s_q  <= s_eff;
                ph_q <= ph_eff;
            end
        end
    end

    conv_puncture_ser u_ser (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .a_bit         (a_bit),
        .b_bit         (b_bit),
        .keep_a        (keep[1]),
        .keep_b        (keep[0]),
        .push          (push),
        .out_bit       (out_bit),
        .output_strobe (output_strobe),
        .can_accept    (can_accept)
    );

endmodule

// File: tb/tb_conv_encoder.sv
module tb_conv_encoder;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] rate = 2'd0;
    logic       frame_start = 1'b0;
    logic       in_bit = 1'b0;
    logic       input_strobe = 1'b0;
    logic       input_ready;
    logic       out_bit;
    logic       output_strobe;

    always #5 clock = ~clock;

    conv_encoder dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .rate          (rate),
        .frame_start   (frame_start),
        .in_bit        (in_bit),
        .input_strobe  (input_strobe),
        .input_ready   (input_ready),
        .out_bit       (out_bit),
        .output_strobe (output_strobe)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: history of accepted bits in the frame, a count of
    // coded pairs for the puncture pattern, and a FIFO of coded bits waiting
    // to be shown on the output.
    logic m_hist[$];
    int   m_npair = 0;
    int   m_rate  = 0;
    logic m_pend[$];
    logic m_shown   = 1'b0;
    logic m_shown_v = 1'b0;
    logic cap[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Input delayed d (d=0 is the bit being encoded); zero before frame start.
    function automatic logic tap(input int d);
        int n;
        n = m_hist.size();
        if (d < n) return m_hist[n - 1 - d];
        return 1'b0;
    endfunction

    function automatic logic [63:0] pack_cap();
        logic [63:0] v;
        v = '0;
        foreach (cap[i]) v = {v[62:0], cap[i]};
        return v;
    endfunction

    task automatic model_edge(input logic rst, input logic en, input logic fs,
                              input logic [1:0] r, input logic acc, input logic b);
        logic       a, bb;
        logic [5:0] pm;
        int         plen, idx;
        if (!rst) begin
            m_pend.delete();
            m_hist.delete();
            m_shown_v = 1'b0;
            m_npair   = 0;
            m_rate    = 0;
        end else if (en) begin
            if (m_pend.size() > 0) begin
                m_shown   = m_pend.pop_front();
                m_shown_v = 1'b1;
            end else begin
                m_shown_v = 1'b0;
            end
            if (fs) begin
                m_hist.delete();
                m_npair = 0;
                m_rate  = (r == 2'd3) ? 0 : int'(r);
            end
            if (acc) begin
                m_hist.push_back(b);
                if (m_hist.size() > 7) void'(m_hist.pop_front());
                a  = tap(0) ^ tap(2) ^ tap(3) ^ tap(5) ^ tap(6);
                bb = tap(0) ^ tap(1) ^ tap(2) ^ tap(3) ^ tap(6);
                // puncture matrices read as A0 B0 A1 B1 A2 B2
                case (m_rate)
                    1:       begin pm = 6'b111000; plen = 2; end
                    2:       begin pm = 6'b111001; plen = 3; end
                    default: begin pm = 6'b110000; plen = 1; end
                endcase
                idx = (m_npair % plen) * 2;
                if (pm[5 - idx]) m_pend.push_back(a);
                if (pm[4 - idx]) m_pend.push_back(bb);
                m_npair++;
            end
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic fs, input logic [1:0] r,
                        input logic vld, input logic b, output logic acc);
        logic exp_strobe, exp_ready;
        reset        = rst;
        enable       = en;
        frame_start  = fs;
        rate         = r;
        input_strobe = vld;
        in_bit       = b;
        @(negedge clock);
        exp_strobe = rst & en & m_shown_v;
        exp_ready  = rst & en & (m_pend.size() <= 1);
        check("output_strobe", 64'(output_strobe), 64'(exp_strobe));
        check("input_ready", 64'(input_ready), 64'(exp_ready));
        if (exp_strobe) check("out_bit", 64'(out_bit), 64'(m_shown));
        if (!rst) check("out_bit_in_reset", 64'(out_bit), 64'd0);
        if (output_strobe === 1'b1) cap.push_back(out_bit);
        acc = exp_ready & vld;
        model_edge(rst, en, fs, r, acc, b);
        @(posedge clock);
        #1;
    endtask

    task automatic feed(input logic [1:0] r, input logic fs, input logic data[$],
                        input int gap_at, input int gap_len);
        logic f, acc, en;
        int   k;
        f = fs;
        k = 0;
        while (data.size() > 0) begin
            en = !(k >= gap_at && k < gap_at + gap_len);
            step(1'b1, en, f, r, 1'b1, data[0], acc);
            f = 1'b0;
            if (acc) void'(data.pop_front());
            k++;
            if (k > 300) begin
                check("feed_timeout", 64'(data.size()), 64'd0);
                break;
            end
        end
    endtask

    task automatic drain(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, acc);
    endtask

    task automatic cap_check(input string tag, input int n, input logic [63:0] expv);
        check({tag, "_len"}, 64'(cap.size()), 64'(n));
        check(tag, pack_cap(), expv);
        cap.delete();
    endtask

    initial begin
        logic        acc;
        logic        q[$];
        logic        stream[$];
        logic [63:0] ref_run;
        int          ref_len;

        // reset held
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, acc);
        drain(2);
        cap.delete();

        // rate 1/2 impulse, saturating
        q = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        feed(2'd0, 1'b1, q, -1, 0);
        drain(4);
        cap_check("impulse_r12", 14, 64'b11011111001011);

        // rate 3/4: 1,0,0 then a fresh frame with 1
        q = {1'b1, 1'b0, 1'b0};
        feed(2'd2, 1'b1, q, -1, 0);
        drain(4);
        cap_check("r34_100", 4, 64'b1101);
        q = {1'b1};
        feed(2'd2, 1'b1, q, -1, 0);
        drain(3);
        cap_check("r34_restart", 2, 64'b11);

        // rate 2/3: 1,0 then a saturating random stream
        q = {1'b1, 1'b0};
        feed(2'd1, 1'b1, q, -1, 0);
        drain(4);
        cap_check("r23_10", 3, 64'b110);
        q.delete();
        for (int i = 0; i < 12; i++) q.push_back(1'($urandom_range(0, 1)));
        feed(2'd1, 1'b1, q, -1, 0);
        drain(4);
        cap.delete();

        // rate 3/4 with and without a 5-cycle enable gap
        stream.delete();
        for (int i = 0; i < 24; i++) stream.push_back(1'($urandom_range(0, 1)));
        feed(2'd2, 1'b1, stream, -1, 0);
        drain(4);
        ref_len = cap.size();
        ref_run = pack_cap();
        cap.delete();
        feed(2'd2, 1'b1, stream, 8, 5);
        drain(4);
        check("gap_len", 64'(cap.size()), 64'(ref_len));
        check("gap_stream", pack_cap(), ref_run);
        cap.delete();

        // frame_start while two bits are pending, new rate 1/2
        q = {1'b1, 1'b0};
        feed(2'd0, 1'b1, q, -1, 0);
        q = {1'b1};
        feed(2'd0, 1'b1, q, -1, 0);
        drain(3);
        cap_check("fs_pending", 6, 64'b110111);

        // reset mid-frame with two bits pending
        q = {1'b1};
        feed(2'd1, 1'b1, q, -1, 0);
        cap.delete();
        step(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, acc);
        step(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, acc);
        q = {1'b1, 1'b1};
        feed(2'd1, 1'b0, q, -1, 0);
        drain(3);
        cap_check("post_reset", 4, 64'b1110);

        // random frames: gaps, enable drops, rate noise outside frame_start
        for (int fr = 0; fr < 10; fr++) begin
            logic [1:0] r;
            logic       fs, en, vld;
            int         n, sent, guard;
            r     = 2'($urandom_range(0, 3));
            n     = int'($urandom_range(5, 30));
            fs    = 1'b1;
            sent  = 0;
            guard = 0;
            while (sent < n && guard < 400) begin
                en  = ($urandom_range(0, 9) != 0);
                vld = ($urandom_range(0, 3) != 0);
                step(1'b1, en, fs, fs ? r : 2'($urandom_range(0, 3)), vld,
                     1'($urandom_range(0, 1)), acc);
                if (en) fs = 1'b0;
                if (acc) sent++;
                guard++;
            end
            check("random_timeout", 64'(sent), 64'(n));
        end
        drain(4);
        check("model_empty", 64'(m_pend.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
